// File: rtl/wf_pixel_frame_loader.sv
// Double-buffered pixel store feeding the neopixel serializer: packs host bytes
// into 24-bit words in the back bank and swaps banks only at a frame boundary.
module wf_pixel_frame_loader #(
   parameter int NUM_OF_PIXELS = 8,
   parameter int ADDR_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] ram_rd_addr,
   output logic [23:0]       ram_rd_data,
   output logic              commit_pending,
   output logic              swap_done
);

   // state      | meaning
   // ST_LOAD    | packing host bytes into the back bank
   // ST_PENDING | back bank holds a full frame, waiting for a serializer boundary
   typedef enum logic {
      ST_LOAD    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OF_PIXELS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_idx;
   logic [ADDR_W-1:0] wr_idx_nxt;
   logic [1:0]        byte_idx;
   logic [1:0]        byte_idx_nxt;
   logic [15:0]       pix_lo;
   logic              front_sel;
   logic              back_sel;
   logic              addr_nz_d;
   logic              byte_ready_q;
   logic              swap_done_q;
   logic              accept;
   logic              boundary;
   logic              wr_en;
   logic              frame_done;
   logic              do_swap;
   logic [23:0]       rd_word;

   logic [23:0] bank [2][NUM_OF_PIXELS];

   assign accept   = byte_valid && byte_ready_q;
   assign boundary = addr_nz_d && (ram_rd_addr == '0);
   assign back_sel = ~front_sel;

   always_comb begin
      state_nxt    = state;
      wr_idx_nxt   = wr_idx;
      byte_idx_nxt = byte_idx;
      wr_en        = 1'b0;
      frame_done   = 1'b0;
      do_swap      = 1'b0;
      case (state)
         ST_LOAD: begin
            // frame_start outranks a byte accepted on the same edge
            if (frame_start) begin
               wr_idx_nxt   = '0;
               byte_idx_nxt = 2'd0;
            end else if (accept) begin
               if (byte_idx == 2'd2) begin
                  wr_en        = 1'b1;
                  byte_idx_nxt = 2'd0;
                  if (wr_idx == LAST_IDX) begin
                     frame_done = 1'b1;
                     wr_idx_nxt = '0;
                     state_nxt  = ST_PENDING;
                  end else begin
                     wr_idx_nxt = wr_idx + 1'b1;
                  end
               end else begin
                  byte_idx_nxt = byte_idx + 2'd1;
               end
            end
         end
         ST_PENDING: begin
            if (boundary) begin
               do_swap      = 1'b1;
               wr_idx_nxt   = '0;
               byte_idx_nxt = 2'd0;
               state_nxt    = ST_LOAD;
            end
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_LOAD;
         wr_idx       <= '0;
         byte_idx     <= 2'd0;
         pix_lo       <= 16'h0;
         front_sel    <= 1'b0;
         addr_nz_d    <= 1'b0;
         byte_ready_q <= 1'b0;
         swap_done_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         wr_idx      <= wr_idx_nxt;
         byte_idx    <= byte_idx_nxt;
         addr_nz_d   <= (ram_rd_addr != '0);
         swap_done_q <= do_swap;
         if (do_swap) begin
            front_sel <= ~front_sel;
         end
         if (state == ST_LOAD && accept && !frame_start) begin
            if (byte_idx == 2'd0) begin
               pix_lo[7:0] <= byte_data;
            end
            if (byte_idx == 2'd1) begin
               pix_lo[15:8] <= byte_data;
            end
         end
         // ready lags commit_pending by a cycle on the swap, but drops on the completing edge
         byte_ready_q <= (state == ST_LOAD) && !frame_done;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_OF_PIXELS; i++) begin
               bank[b][i] <= 24'h0;
            end
         end
      end else if (wr_en) begin
         for (int i = 0; i < NUM_OF_PIXELS; i++) begin
            if (wr_idx == ADDR_W'(i)) begin
               bank[back_sel][i] <= {byte_data, pix_lo};
            end
         end
      end
   end

   // out-of-range addresses fall through to zero
   always_comb begin
      rd_word = 24'h0;
      for (int i = 0; i < NUM_OF_PIXELS; i++) begin
         if (ram_rd_addr == ADDR_W'(i)) begin
            rd_word = bank[front_sel][i];
         end
      end
   end

   assign ram_rd_data    = rd_word;
   assign byte_ready     = byte_ready_q;
   assign commit_pending = (state == ST_PENDING);
   assign swap_done      = swap_done_q;

endmodule

// File: tb/tb_wf_pixel_frame_loader.sv
// Scoreboard bench for wf_pixel_frame_loader with a two-pixel frame: completed
// frames are queued as stimulus is driven and popped when the DUT swaps banks.
module tb_wf_pixel_frame_loader;

   localparam int NPIX   = 2;
   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst_n;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready;
   logic              frame_start;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [23:0]       ram_rd_data;
   logic              commit_pending;
   logic              swap_done;

   wf_pixel_frame_loader #(.NUM_OF_PIXELS(NPIX), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .frame_start    (frame_start),
      .ram_rd_addr    (ram_rd_addr),
      .ram_rd_data    (ram_rd_data),
      .commit_pending (commit_pending),
      .swap_done      (swap_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_vec;
   int          n_bad;
   logic [23:0] exp_q[$];
   logic [23:0] part_q[$];
   logic [23:0] front_mdl [NPIX];
   logic [23:0] mdl_word;
   int          mdl_bidx;
   bit          mdl_pending;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      exp_q.delete();
      part_q.delete();
      for (int i = 0; i < NPIX; i++) front_mdl[i] = 24'h0;
      mdl_word    = 24'h0;
      mdl_bidx    = 0;
      mdl_pending = 1'b0;
   endtask

   task automatic mdl_accept(input logic [7:0] b);
      case (mdl_bidx)
         0: mdl_word[7:0]   = b;
         1: mdl_word[15:8]  = b;
         default: mdl_word[23:16] = b;
      endcase
      if (mdl_bidx == 2) begin
         mdl_bidx = 0;
         part_q.push_back(mdl_word);
         if (part_q.size() == NPIX) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            mdl_pending = 1'b1;
         end
      end else begin
         mdl_bidx++;
      end
   endtask

   // called at posedge+1; waits (bounded) for ready, then transfers one byte
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         chk("send_timeout", 32'(n), 32'd0);
      end else begin
         @(posedge clk); #1;
         mdl_accept(b);
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulse_frame_start(input bit with_byte, input logic [7:0] b);
      frame_start = 1'b1;
      byte_valid  = with_byte;
      byte_data   = b;
      @(posedge clk); #1;
      frame_start = 1'b0;
      byte_valid  = 1'b0;
      if (!mdl_pending) begin
         part_q.delete();
         mdl_bidx = 0;
      end
   endtask

   task automatic read_front(input string tag);
      logic [ADDR_W-1:0] keep;
      logic [ADDR_W-1:0] addrs [4];
      keep     = ram_rd_addr;
      addrs[0] = 8'd0;
      addrs[1] = 8'd1;
      addrs[2] = 8'd2;
      addrs[3] = 8'd5;
      for (int k = 0; k < 4; k++) begin
         ram_rd_addr = addrs[k];
         #1;
         if (addrs[k] < NPIX) chk(tag, 32'(ram_rd_data), 32'(front_mdl[addrs[k]]));
         else                 chk({tag, "_oob"}, 32'(ram_rd_data), 32'd0);
      end
      ram_rd_addr = keep;
   endtask

   task automatic do_boundary();
      bit exp_swap;
      exp_swap    = mdl_pending;
      ram_rd_addr = 8'd2;
      @(posedge clk); #1;
      ram_rd_addr = 8'd0;
      @(posedge clk); #1;
      chk("swap_done", 32'(swap_done), 32'(exp_swap));
      if (exp_swap) begin
         for (int i = 0; i < NPIX; i++) begin
            if (exp_q.size() > 0) front_mdl[i] = exp_q.pop_front();
            else chk("sb_underflow", 32'(exp_q.size()), 32'd1);
         end
         mdl_pending = 1'b0;
         mdl_bidx    = 0;
         chk("commit_clr", 32'(commit_pending), 32'd0);
         chk("rdy_at_swap", 32'(byte_ready), 32'd0);
      end
      @(posedge clk); #1;
      chk("swap_done_end", 32'(swap_done), 32'd0);
      chk("rdy_after_swap", 32'(byte_ready), 32'(!mdl_pending));
   endtask

   initial begin
      int          cnt;
      bit          acc;
      logic [7:0]  seq1 [6];
      logic [7:0]  seq2 [6];
      n_vec = 0;
      n_bad = 0;
      mdl_reset();
      seq1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      seq2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      rst_n       = 1'b0;
      byte_data   = 8'h0;
      byte_valid  = 1'b0;
      frame_start = 1'b0;
      ram_rd_addr = '0;

      // reset values
      #12;
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_commit", 32'(commit_pending), 32'd0);
      chk("rst_swap", 32'(swap_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_release", 32'(byte_ready), 32'd1);
      chk("commit_release", 32'(commit_pending), 32'd0);
      read_front("rd_reset");

      // first frame with address held nonzero: no swap yet
      ram_rd_addr = 8'd1;
      foreach (seq1[i]) send_byte(seq1[i]);
      chk("commit_full", 32'(commit_pending), 32'd1);
      chk("ready_full", 32'(byte_ready), 32'd0);
      read_front("rd_before_swap");
      do_boundary();
      read_front("rd_frame1");
      chk("frame1_p0", 32'(front_mdl[0]), 32'h332211);
      chk("frame1_p1", 32'(front_mdl[1]), 32'h665544);

      // aborted partial frame, including a byte colliding with frame_start
      ram_rd_addr = 8'd1;
      send_byte(8'h01);
      send_byte(8'h02);
      pulse_frame_start(1'b1, 8'h03);
      foreach (seq2[i]) send_byte(seq2[i]);
      chk("commit_f2", 32'(commit_pending), 32'd1);
      do_boundary();
      read_front("rd_frame2");
      chk("frame2_p0", 32'(front_mdl[0]), 32'hCCBBAA);
      chk("frame2_p1", 32'(front_mdl[1]), 32'hFFEEDD);

      // valid held high across completion; extra bytes must be refused
      ram_rd_addr = 8'd1;
      cnt = 0;
      byte_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         byte_data = 8'h50 + 8'(k);
         chk("rdy_hold", 32'(byte_ready), 32'(!mdl_pending));
         acc = !mdl_pending;
         @(posedge clk); #1;
         if (acc) begin
            mdl_accept(byte_data);
            cnt++;
         end
      end
      byte_valid = 1'b0;
      chk("hold_count", 32'(cnt), 32'd6);
      pulse_frame_start(1'b0, 8'h00);
      chk("fs_ignored", 32'(commit_pending), 32'd1);
      read_front("rd_hold_pending");
      do_boundary();
      read_front("rd_frame3");

      // async reset while a frame is pending and the front bank is populated
      ram_rd_addr = 8'd1;
      for (int k = 0; k < 6; k++) send_byte(8'h90 + 8'(k));
      chk("commit_f4", 32'(commit_pending), 32'd1);
      ram_rd_addr = 8'd0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_commit", 32'(commit_pending), 32'd0);
      chk("async_ready", 32'(byte_ready), 32'd0);
      chk("async_swap", 32'(swap_done), 32'd0);
      chk("async_rd0", 32'(ram_rd_data), 32'd0);
      mdl_reset();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_rerelease", 32'(byte_ready), 32'd1);
      do_boundary();
      read_front("rd_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
